decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter PAYLOAD_W, default 128, width of one decoded-instruction control/operand bundle.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-003 Parameter CNT_W, default $clog2(DEPTH)+1, width of occupancy count.
REQ-004 Port clk  input  1  system clock; one clock domain.
REQ-005 Port Rst  input  1  reset, asynchronous, active-high.
REQ-006 Port in_valid  input  1  decode stage presents an instruction.
REQ-007 Port in_ready  output  1  queue accepts an instruction this cycle.
REQ-008 Port in_payload  input  PAYLOAD_W  decoded bundle.
REQ-009 Port in_rd  input  5  destination register of the incoming instruction.
REQ-010 Port in_regwrite  input  1  incoming instruction writes in_rd.
REQ-011 Port in_memread  input  1  incoming instruction is a load.
REQ-012 Port out_valid  output  1  head entry is valid.
REQ-013 Port out_ready  input  1  execute stage consumes the head entry.
REQ-014 Port out_payload  output  PAYLOAD_W  head bundle.
REQ-015 Port out_rd, out_regwrite, out_memread  output  5/1/1  head sideband fields.
REQ-016 Port flush  input  1  branch-taken or trap squash; discards all entries.
REQ-017 Port hold  input  1  debug halt or memory hold; freezes the queue.
REQ-018 Port query_rs1, query_rs2  input  5  source registers of the instruction in decode.
REQ-019 Port load_hz  output  1  a queued load writes query_rs1 or query_rs2.
REQ-020 Port count  output  CNT_W  number of valid entries.

Function
REQ-021 The queue SHALL be a circular buffer with head/tail pointers that wrap modulo DEPTH.
REQ-022 in_ready SHALL equal !full && !hold && !flush, where full means count==DEPTH.
REQ-023 A push SHALL occur on a rising clk when in_valid && in_ready; the entry stores in_payload, in_rd, in_regwrite, in_memread at tail.
REQ-024 out_valid SHALL equal (count!=0) && !hold.
REQ-025 A pop SHALL occur on a rising clk when out_valid && out_ready && !flush; head advances by one.
REQ-026 Latency SHALL be one cycle from push to out_valid; no combinational input-to-output bypass.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-028 When full, a pop in the same cycle SHALL NOT enable a push; in_ready stays low.
REQ-029 When count==0, out_payload, out_rd, out_regwrite and out_memread SHALL be driven to zero.
REQ-030 flush SHALL, on the next rising clk, set count, head and tail to zero, overriding any push or pop in that cycle.
REQ-031 hold SHALL freeze all state; flush has priority over hold.
REQ-032 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.
REQ-033 load_hz SHALL be combinational: high when any valid entry has memread=1, regwrite=1, rd!=0, and rd equal to query_rs1 or query_rs2.
REQ-034 Entries outside the valid window SHALL NOT contribute to load_hz.

Reset
REQ-035 On Rst high, head, tail and count SHALL clear to 0 asynchronously, and out_valid, load_hz and all out_* fields SHALL read 0.
REQ-036 in_ready SHALL be 0 while Rst is high and 1 on the first cycle after release, unless hold or flush is high.
REQ-037 Rst asserted mid-operation SHALL discard all entries; no stale entry reappears after release.
REQ-038 Storage array contents need not be reset; outputs SHALL be masked by valid state.

Verification
REQ-039 Push payloads 0x1,0x2,0x3,0x4 with DEPTH=4 and out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> payloads 0x1..0x4 pop in order, count reaches 0, out_valid=0.
REQ-040 Full queue, in_valid=1 and out_ready=1 for one cycle -> one pop, no push, count=3; the following cycle push and pop together keep count=3.
REQ-041 Queue holding 3 entries, flush=1 while in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the pushed entry is dropped.
REQ-042 Queued load rd=5, query_rs2=5 -> load_hz=1; rd=0 or regwrite=0 or entry popped -> load_hz=0.
REQ-043 Issue 10 push/pop cycles so pointers wrap twice -> FIFO order preserved; hold=1 for 3 cycles mid-stream -> no state change, in_ready=0, out_valid=0.
REQ-044 Rst pulsed asynchronously between clock edges with 2 entries queued -> outputs zero immediately; after release count=0, in_ready=1.

Source files
------------

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - circular decoded-instruction queue with load-use hazard lookup
//
// Buffers decoded instructions between the decode and execute stages. Each entry
// holds a payload bundle plus the destination register and the regwrite/memread
// sideband flags. The sideband flags feed a combinational lookup that reports
// whether any queued load writes a register that the instruction now in decode
// reads.
//
// Ports:
//   clk          system clock
//   Rst          asynchronous active-high reset
//   in_valid     decode stage presents an instruction
//   in_ready     queue accepts an instruction this cycle
//   in_payload   decoded bundle (PAYLOAD_W)
//   in_rd        destination register of the incoming instruction
//   in_regwrite  incoming instruction writes in_rd
//   in_memread   incoming instruction is a load
//   out_valid    head entry is valid
//   out_ready    execute stage consumes the head entry
//   out_payload  head bundle (zero when the queue is empty)
//   out_rd       head destination register (zero when empty)
//   out_regwrite head regwrite flag (zero when empty)
//   out_memread  head memread flag (zero when empty)
//   flush        squash: discards all entries on the next edge
//   hold         freezes the queue (flush still wins)
//   query_rs1    first source register of the instruction in decode
//   query_rs2    second source register of the instruction in decode
//   load_hz      a queued load writes query_rs1 or query_rs2
//   count        number of valid entries (CNT_W)
module decode_queue #(
  parameter int PAYLOAD_W = 128,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_rd,
  input  logic                 in_regwrite,
  input  logic                 in_memread,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_rd,
  output logic                 out_regwrite,
  output logic                 out_memread,
  input  logic                 flush,
  input  logic                 hold,
  input  logic [4:0]           query_rs1,
  input  logic [4:0]           query_rs2,
  output logic                 load_hz,
  output logic [CNT_W-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] mem_payload  [DEPTH];
  logic [4:0]           mem_rd       [DEPTH];
  logic                 mem_regwrite [DEPTH];
  logic                 mem_memread  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Rst is folded in so in_ready reads low for the whole reset pulse, not just
  // after the asynchronous clear has propagated through count.
  assign in_ready  = !full && !hold && !flush && !Rst;
  assign out_valid = !empty && !hold;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // hold needs no branch: it already forces push and pop low.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; every reader below masks it with the valid window.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_payload[tail]  <= in_payload;
      mem_rd[tail]       <= in_rd;
      mem_regwrite[tail] <= in_regwrite;
      mem_memread[tail]  <= in_memread;
    end
  end

  assign out_payload  = empty ? '0    : mem_payload[head];
  assign out_rd       = empty ? 5'd0  : mem_rd[head];
  assign out_regwrite = empty ? 1'b0  : mem_regwrite[head];
  assign out_memread  = empty ? 1'b0  : mem_memread[head];

  // An entry is live when its distance from head (modulo DEPTH) is below count.
  // With count==DEPTH every distance qualifies, so a full queue needs no special case.
  logic [PTR_W-1:0] entry_offs [DEPTH];
  logic [DEPTH-1:0] entry_hz;

  for (genvar i = 0; i < DEPTH; i++) begin : g_hz
    assign entry_offs[i] = PTR_W'(i) - head;
    assign entry_hz[i]   = (CNT_W'(entry_offs[i]) < count)
                           && mem_memread[i] && mem_regwrite[i]
                           && (mem_rd[i] != 5'd0)
                           && ((mem_rd[i] == query_rs1) || (mem_rd[i] == query_rs2));
  end

  assign load_hz = |entry_hz;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;

  localparam int PAYLOAD_W = 128;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [4:0]           in_rd;
  logic                 in_regwrite;
  logic                 in_memread;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [4:0]           out_rd;
  logic                 out_regwrite;
  logic                 out_memread;
  logic                 flush;
  logic                 hold;
  logic [4:0]           query_rs1;
  logic [4:0]           query_rs2;
  logic                 load_hz;
  logic [CNT_W-1:0]     count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_queue #(.PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .Rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_rd       (in_rd),
    .in_regwrite (in_regwrite),
    .in_memread  (in_memread),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_rd      (out_rd),
    .out_regwrite(out_regwrite),
    .out_memread (out_memread),
    .flush       (flush),
    .hold        (hold),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .load_hz     (load_hz),
    .count       (count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [127:0] p, input logic [4:0] rd,
                        input logic rw, input logic mr);
    in_valid    = v;
    in_payload  = p;
    in_rd       = rd;
    in_regwrite = rw;
    in_memread  = mr;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    flush     = 1'b0;
    hold      = 1'b0;
    query_rs1 = 5'd0;
    query_rs2 = 5'd0;
    #2;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_load_hz", 128'(load_hz), 128'd0);
    chk("rst_out_payload", out_payload, 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Fill 0x1..0x4, then drain in order.
    for (int p = 1; p <= 4; p++) begin
      set_in(1'b1, 128'(p), 5'd0, 1'b0, 1'b0);
      tick();
      if (p == 1) begin
        chk("latency_out_valid", 128'(out_valid), 128'd1);
        chk("latency_out_payload", out_payload, 128'h1);
      end
    end
    chk("fill_count", 128'(count), 128'd4);
    chk("fill_in_ready", 128'(in_ready), 128'd0);
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      #1;
      chk("drain_out_valid", 128'(out_valid), 128'd1);
      chk("drain_payload", out_payload, 128'(p));
      tick();
    end
    chk("drain_count", 128'(count), 128'd0);
    chk("drain_out_valid_low", 128'(out_valid), 128'd0);
    chk("empty_payload_zero", out_payload, 128'd0);

    // Full queue: pop without push, then push and pop together.
    out_ready = 1'b0;
    for (int p = 'h11; p <= 'h14; p++) begin
      set_in(1'b1, 128'(p), 5'd0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 128'h15, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 128'(in_ready), 128'd0);
    tick();
    chk("full_pop_count", 128'(count), 128'd3);
    chk("full_pop_head", out_payload, 128'h12);
    set_in(1'b1, 128'h16, 5'd0, 1'b0, 1'b0);
    #1;
    chk("pushpop_in_ready", 128'(in_ready), 128'd1);
    tick();
    chk("pushpop_count", 128'(count), 128'd3);
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    chk("pushpop_head0", out_payload, 128'h13);
    tick();
    chk("pushpop_head1", out_payload, 128'h14);
    tick();
    chk("pushpop_head2", out_payload, 128'h16);
    tick();
    chk("pushpop_empty", 128'(count), 128'd0);

    // Flush with simultaneous push and pop.
    out_ready = 1'b0;
    for (int p = 'h21; p <= 'h23; p++) begin
      set_in(1'b1, 128'(p), 5'd0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 128'h24, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    tick();
    flush = 1'b0;
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    tick();
    chk("flush_dropped", 128'(count), 128'd0);

    // Load-use hazard lookup.
    query_rs1 = 5'd7;
    query_rs2 = 5'd5;
    set_in(1'b1, 128'h31, 5'd5, 1'b1, 1'b1);
    tick();
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("hz_rs2_hit", 128'(load_hz), 128'd1);
    chk("hz_out_rd", 128'(out_rd), 128'd5);
    chk("hz_out_memread", 128'(out_memread), 128'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("hz_popped", 128'(load_hz), 128'd0);
    query_rs1 = 5'd0;
    set_in(1'b1, 128'h32, 5'd0, 1'b1, 1'b1);
    tick();
    set_in(1'b1, 128'h33, 5'd5, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("hz_rd0_noreg", 128'(load_hz), 128'd0);
    query_rs1 = 5'd9;
    query_rs2 = 5'd0;
    set_in(1'b1, 128'h34, 5'd9, 1'b1, 1'b1);
    tick();
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    #1;
    chk("hz_rs1_hit", 128'(load_hz), 128'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("hz_after_flush", 128'(load_hz), 128'd0);

    // Streaming push+pop with wrap, hold in the middle.
    set_in(1'b1, 128'h40, 5'd0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 128'('h40 + i), 5'd0, 1'b0, 1'b0);
      #1;
      chk("stream_head", out_payload, 128'('h40 + i - 1));
      tick();
      chk("stream_count", 128'(count), 128'd1);
      if (i == 5) begin
        hold = 1'b1;
        set_in(1'b1, 128'h99, 5'd0, 1'b0, 1'b0);
        for (int h = 0; h < 3; h++) begin
          #1;
          chk("hold_in_ready", 128'(in_ready), 128'd0);
          chk("hold_out_valid", 128'(out_valid), 128'd0);
          tick();
          chk("hold_count", 128'(count), 128'd1);
        end
        hold = 1'b0;
      end
    end
    chk("stream_final_head", out_payload, 128'h4A);

    // Asynchronous reset between edges with two entries queued.
    out_ready = 1'b0;
    set_in(1'b1, 128'h4B, 5'd0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 5'd0, 1'b0, 1'b0);
    chk("pre_rst_count", 128'(count), 128'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 128'(count), 128'd0);
    chk("async_rst_out_valid", 128'(out_valid), 128'd0);
    chk("async_rst_payload", out_payload, 128'd0);
    chk("async_rst_in_ready", 128'(in_ready), 128'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_async_count", 128'(count), 128'd0);
    chk("post_async_in_ready", 128'(in_ready), 128'd1);
    chk("post_async_out_valid", 128'(out_valid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
